// File: rtl/if_stage_pf.sv
// Instruction-fetch stage: synchronous-read IMEM feeding a small prefetch FIFO,
// with redirect/flush, fetch enable and a boot-time IMEM write port.
module if_stage_pf #(
    parameter int unsigned     XLEN        = 16,
    parameter int unsigned     ILEN        = 16,
    parameter int unsigned     IMEM_DEPTH  = 256,
    parameter int unsigned     INSTR_BYTES = 2,
    parameter int unsigned     FIFO_DEPTH  = 2,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_en,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [ILEN-1:0]               imem_wdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ILEN-1:0]               out_instr,
    output logic [XLEN-1:0]               out_pc,
    output logic [XLEN-1:0]               fetch_pc
);

    localparam int unsigned IDX_W    = $clog2(IMEM_DEPTH);
    localparam int unsigned PC_SHIFT = $clog2(INSTR_BYTES);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned OCC_W    = CNT_W + 1;

    logic [ILEN-1:0]  mem [IMEM_DEPTH];
    logic [ILEN-1:0]  rdata_q;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  inflight_pc_q;
    logic             inflight_q;

    logic [ILEN-1:0]  fifo_instr_q [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_pc_q    [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             pop, push, issue;
    logic [OCC_W-1:0] occupancy;
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
        out_valid = (count_q != '0);
        pop       = out_valid & out_ready;
        push      = inflight_q & ~redirect_valid;
        // Slots already claimed after this cycle's pop; an issue must leave room for its push.
        occupancy = {1'b0, count_q} + OCC_W'(inflight_q) - OCC_W'(pop);
        issue     = fetch_en & ~redirect_valid & (occupancy < OCC_W'(FIFO_DEPTH));
        rd_idx    = IDX_W'(fetch_pc_q >> PC_SHIFT);

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
        end
    end

    // IMEM is never reset; a same-index read and write returns the old word.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
        if (issue) begin
            rdata_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
            end
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    fifo_instr_q[wr_ptr_q] <= rdata_q;
                    fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
                    wr_ptr_q               <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_comb begin
        out_instr = fifo_instr_q[rd_ptr_q];
        out_pc    = fifo_pc_q[rd_ptr_q];
        fetch_pc  = fetch_pc_q;
    end

endmodule
